// File: rtl/dshot_pkg.sv
// Shared types, constants and helpers for the DShot link scheduler.
package dshot_pkg;

    typedef enum logic [1:0] {
        DISARMED,
        ARMING,
        ARMED,
        FAILSAFE
    } link_state_e;

    localparam int unsigned CMD_MAX         = 47;
    localparam int unsigned THROTTLE_OFFSET = 47;

    function automatic logic is_repeat_cmd(input logic [5:0] cmd);
        case (cmd)
            6'd7, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd20, 6'd21: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Low nibble of d ^ d>>4 ^ d>>8 is the XOR of the three payload nibbles.
    function automatic logic [3:0] dshot_crc(input logic [11:0] d);
        return d[11:8] ^ d[7:4] ^ d[3:0];
    endfunction

endpackage

// File: rtl/dshot_frame_check.sv
// Combinational split, CRC check and classification of one received DShot frame.
module dshot_frame_check
    import dshot_pkg::*;
(
    input  logic        frame_strobe,
    input  logic [15:0] frame_data,
    output logic [10:0] throttle,
    output logic        telem,
    output logic [5:0]  cmd,
    output logic        is_valid,
    output logic        is_bad,
    output logic        is_zero,
    output logic        is_cmd,
    output logic        is_speed
);

    logic crc_ok;

    always_comb begin
        throttle = frame_data[15:5];
        telem    = frame_data[4];
        cmd      = frame_data[10:5];
        crc_ok   = dshot_crc(frame_data[15:4]) == frame_data[3:0];
        is_valid = frame_strobe && crc_ok;
        is_bad   = frame_strobe && !crc_ok;
        is_zero  = is_valid && (throttle == 11'd0);
        is_cmd   = is_valid && (throttle != 11'd0) && (throttle <= 11'(CMD_MAX));
        is_speed = is_valid && (throttle > 11'(CMD_MAX));
    end

endmodule

// File: rtl/dshot_link_scheduler.sv
// Arm/disarm sequencing, command repeat gating and link-loss failsafe for received DShot frames.
module dshot_link_scheduler
    import dshot_pkg::*;
#(
    parameter int unsigned ARM_FRAMES     = 10,
    parameter int unsigned REPEAT_FRAMES  = 6,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned ERR_LIMIT      = 4
) (
    input  logic        quarterClockOut,
    input  logic        reset,
    input  logic        frame_strobe,
    input  logic [15:0] frame_data,
    output logic [10:0] motor_speed,
    output logic        speed_update,
    output logic [5:0]  cmd_code,
    output logic        cmd_strobe,
    output logic        cmd_reject,
    output logic        telem_req,
    output logic        armed,
    output logic        failsafe,
    output logic [7:0]  crc_err_count
);

    localparam int unsigned ArmW = $clog2(ARM_FRAMES) + 1;
    localparam int unsigned RepW = $clog2(REPEAT_FRAMES) + 1;
    localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned ErrW = $clog2(ERR_LIMIT) + 1;

    localparam logic [ArmW-1:0] ArmMax = ARM_FRAMES[ArmW-1:0];
    localparam logic [RepW-1:0] RepMax = REPEAT_FRAMES[RepW-1:0];
    localparam logic [ToW-1:0]  ToMax  = TIMEOUT_CYCLES[ToW-1:0];
    localparam logic [ErrW-1:0] ErrMax = ERR_LIMIT[ErrW-1:0];

    logic [10:0] throttle;
    logic        telem;
    logic [5:0]  cmd;
    logic        is_valid, is_bad, is_zero, is_cmd, is_speed;

    dshot_frame_check u_frame_check (
        .frame_strobe (frame_strobe),
        .frame_data   (frame_data),
        .throttle     (throttle),
        .telem        (telem),
        .cmd          (cmd),
        .is_valid     (is_valid),
        .is_bad       (is_bad),
        .is_zero      (is_zero),
        .is_cmd       (is_cmd),
        .is_speed     (is_speed)
    );

    link_state_e     state_q, state_d;
    logic [ArmW-1:0] arm_cnt_q, arm_cnt_d;
    logic [5:0]      rep_cmd_q, rep_cmd_d;
    logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
    logic [ToW-1:0]  to_cnt_q, to_cnt_d;
    logic [ErrW-1:0] err_cnt_q, err_cnt_d;
    logic [7:0]      crc_err_count_q, crc_err_count_d;
    logic [10:0]     motor_speed_q, motor_speed_d;
    logic [5:0]      cmd_code_q, cmd_code_d;
    logic            speed_update_q, speed_update_d;
    logic            cmd_strobe_q, cmd_strobe_d;
    logic            cmd_reject_q, cmd_reject_d;
    logic            telem_req_q, telem_req_d;

    logic cmd_ok, first_frame, fire, fs_entry;

    always_comb begin
        state_d         = state_q;
        arm_cnt_d       = arm_cnt_q;
        rep_cmd_d       = rep_cmd_q;
        rep_cnt_d       = rep_cnt_q;
        to_cnt_d        = to_cnt_q;
        err_cnt_d       = err_cnt_q;
        crc_err_count_d = crc_err_count_q;
        motor_speed_d   = motor_speed_q;
        cmd_code_d      = cmd_code_q;
        speed_update_d  = 1'b0;
        cmd_strobe_d    = 1'b0;
        cmd_reject_d    = 1'b0;
        telem_req_d     = is_valid && telem;
        cmd_ok          = 1'b0;
        first_frame     = 1'b0;
        fire            = 1'b0;
        fs_entry        = 1'b0;

        if (is_valid) begin
            to_cnt_d  = '0;
            err_cnt_d = '0;
        end else begin
            if (to_cnt_q != ToMax) to_cnt_d = to_cnt_q + ToW'(1);
            if (is_bad && err_cnt_q != ErrMax) err_cnt_d = err_cnt_q + ErrW'(1);
        end
        if (is_bad && crc_err_count_q != 8'hff) crc_err_count_d = crc_err_count_q + 8'd1;
        if (is_zero || is_speed) rep_cnt_d = '0;

        case (state_q)
            DISARMED, FAILSAFE: begin
                if (is_zero) begin
                    arm_cnt_d = ArmW'(1);
                    state_d   = (ARM_FRAMES == 1) ? ARMED : ARMING;
                end
                cmd_ok = is_cmd && (state_q == DISARMED);
            end
            ARMING: begin
                if (is_zero) begin
                    arm_cnt_d = arm_cnt_q + ArmW'(1);
                    if (arm_cnt_d == ArmMax) state_d = ARMED;
                end else if (is_cmd || is_speed) begin
                    arm_cnt_d = '0;
                    state_d   = DISARMED;
                end
                cmd_ok = is_cmd;
            end
            ARMED: begin
                if (is_zero || is_speed) begin
                    motor_speed_d  = is_speed ? throttle - 11'(THROTTLE_OFFSET) : 11'd0;
                    speed_update_d = 1'b1;
                end
                cmd_ok       = is_cmd && (motor_speed_q == 11'd0);
                cmd_reject_d = is_cmd && (motor_speed_q != 11'd0);
            end
            default: ;
        endcase

        // A run restarts on a new code or after a zero/speed frame emptied the count.
        if (cmd_ok) begin
            first_frame = (cmd != rep_cmd_q) || (rep_cnt_q == '0);
            if (first_frame) begin
                rep_cmd_d = cmd;
                rep_cnt_d = RepW'(1);
            end else if (rep_cnt_q != RepMax) begin
                rep_cnt_d = rep_cnt_q + RepW'(1);
            end
            if (is_repeat_cmd(cmd)) begin
                fire = (rep_cnt_d == RepMax) && (first_frame || rep_cnt_q != RepMax);
            end else begin
                fire = first_frame;
            end
            if (fire) begin
                cmd_strobe_d = 1'b1;
                cmd_code_d   = cmd;
            end
        end

        // A valid frame in the expiry cycle keeps the link alive.
        fs_entry = (state_q == ARMING || state_q == ARMED) && !is_valid &&
                   (to_cnt_q == ToMax || (is_bad && err_cnt_d == ErrMax));
        if (fs_entry) begin
            state_d        = FAILSAFE;
            arm_cnt_d      = '0;
            motor_speed_d  = 11'd0;
            speed_update_d = 1'b1;
        end
    end

    always_ff @(posedge quarterClockOut) begin
        if (reset) begin
            state_q         <= DISARMED;
            arm_cnt_q       <= '0;
            rep_cmd_q       <= '0;
            rep_cnt_q       <= '0;
            to_cnt_q        <= '0;
            err_cnt_q       <= '0;
            crc_err_count_q <= '0;
            motor_speed_q   <= '0;
            cmd_code_q      <= '0;
            speed_update_q  <= 1'b0;
            cmd_strobe_q    <= 1'b0;
            cmd_reject_q    <= 1'b0;
            telem_req_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            arm_cnt_q       <= arm_cnt_d;
            rep_cmd_q       <= rep_cmd_d;
            rep_cnt_q       <= rep_cnt_d;
            to_cnt_q        <= to_cnt_d;
            err_cnt_q       <= err_cnt_d;
            crc_err_count_q <= crc_err_count_d;
            motor_speed_q   <= motor_speed_d;
            cmd_code_q      <= cmd_code_d;
            speed_update_q  <= speed_update_d;
            cmd_strobe_q    <= cmd_strobe_d;
            cmd_reject_q    <= cmd_reject_d;
            telem_req_q     <= telem_req_d;
        end
    end

    assign motor_speed   = motor_speed_q;
    assign speed_update  = speed_update_q;
    assign cmd_code      = cmd_code_q;
    assign cmd_strobe    = cmd_strobe_q;
    assign cmd_reject    = cmd_reject_q;
    assign telem_req     = telem_req_q;
    assign armed         = (state_q == ARMED);
    assign failsafe      = (state_q == FAILSAFE);
    assign crc_err_count = crc_err_count_q;

endmodule
